// File: rtl/alu_op_issue.sv
// alu_op_issue: decode/issue stage in front of the ALU.
// Decodes MIPS ALU-class instructions (SPECIAL R-type shifts/logic/arith and
// the I-type immediate ALU ops) into a binary ALU opcode plus two operands.
// The result is held in one registered ID/EX slot with valid/ready on both sides.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   flush        drop the held slot and the incoming instruction this cycle
//   in_valid     upstream presents inst/pc/operands
//   in_ready     stage accepts this cycle (combinational)
//   in_inst      instruction word
//   in_pc        instruction PC
//   in_rs_value  GPR[rs], already forwarded
//   in_rt_value  GPR[rt], already forwarded
//   out_valid    slot holds a decoded instruction
//   out_ready    EX consumes the slot this cycle
//   out_aluop    0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,11 lui
//   out_src1     ALU operand 1 (shift amount in [4:0] for shifts)
//   out_src2     ALU operand 2
//   out_dest     destination GPR
//   out_we       GPR write enable
//   out_pc       PC of held instruction
//   out_illegal  held instruction is not ALU-class
module alu_op_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs_value,
  input  logic [31:0] in_rt_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_aluop,
  output logic [31:0] out_src1,
  output logic [31:0] out_src2,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  // Major opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU opcodes
  localparam logic [AW-1:0] ALU_ADD  = 5'd0;
  localparam logic [AW-1:0] ALU_SUB  = 5'd1;
  localparam logic [AW-1:0] ALU_SLT  = 5'd2;
  localparam logic [AW-1:0] ALU_SLTU = 5'd3;
  localparam logic [AW-1:0] ALU_AND  = 5'd4;
  localparam logic [AW-1:0] ALU_NOR  = 5'd5;
  localparam logic [AW-1:0] ALU_OR   = 5'd6;
  localparam logic [AW-1:0] ALU_XOR  = 5'd7;
  localparam logic [AW-1:0] ALU_SLL  = 5'd8;
  localparam logic [AW-1:0] ALU_SRL  = 5'd9;
  localparam logic [AW-1:0] ALU_SRA  = 5'd10;
  localparam logic [AW-1:0] ALU_LUI  = 5'd11;

  // Instruction fields
  logic [5:0]    f_op;
  logic [RW-1:0] f_rt;
  logic [RW-1:0] f_rd;
  logic [4:0]    f_sa;
  logic [5:0]    f_fn;
  logic [15:0]   f_imm;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;

  assign f_op     = in_inst[31:26];
  assign f_rt     = in_inst[20:16];
  assign f_rd     = in_inst[15:11];
  assign f_sa     = in_inst[10:6];
  assign f_fn     = in_inst[5:0];
  assign f_imm    = in_inst[15:0];
  assign imm_sext = {{(DW-16){f_imm[15]}}, f_imm};
  assign imm_zext = {{(DW-16){1'b0}}, f_imm};

  // The rs field is never needed: its value arrives already read on in_rs_value.
  logic unused_rs_field;
  assign unused_rs_field = ^in_inst[25:21];

  // Decoded (not yet registered) instruction
  logic [AW-1:0] dec_aluop;
  logic [DW-1:0] dec_src1;
  logic [DW-1:0] dec_src2;
  logic [RW-1:0] dec_dest;
  logic          dec_legal;
  logic          dec_we;

  // Instruction decode; anything unmatched leaves the all-zero illegal default
  always_comb begin
    dec_aluop = ALU_ADD;
    dec_src1  = '0;
    dec_src2  = '0;
    dec_dest  = '0;
    dec_legal = 1'b0;

    unique case (f_op)
      OP_SPECIAL: begin
        dec_legal = 1'b1;
        unique case (f_fn)
          FN_ADDU: dec_aluop = ALU_ADD;
          FN_SUBU: dec_aluop = ALU_SUB;
          FN_SLT:  dec_aluop = ALU_SLT;
          FN_SLTU: dec_aluop = ALU_SLTU;
          FN_AND:  dec_aluop = ALU_AND;
          FN_NOR:  dec_aluop = ALU_NOR;
          FN_OR:   dec_aluop = ALU_OR;
          FN_XOR:  dec_aluop = ALU_XOR;
          FN_SLL,
          FN_SLLV: dec_aluop = ALU_SLL;
          FN_SRL,
          FN_SRLV: dec_aluop = ALU_SRL;
          FN_SRA,
          FN_SRAV: dec_aluop = ALU_SRA;
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          // Immediate shifts take the amount from sa; variable shifts from rs
          if (f_fn == FN_SLL || f_fn == FN_SRL || f_fn == FN_SRA) begin
            dec_src1 = DW'(f_sa);
          end else begin
            dec_src1 = in_rs_value;
          end
          dec_src2 = in_rt_value;
          dec_dest = f_rd;
        end
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec_legal = 1'b1;
        dec_aluop = (f_op == OP_ADDIU) ? ALU_ADD :
                    (f_op == OP_SLTI)  ? ALU_SLT : ALU_SLTU;
        dec_src1  = in_rs_value;
        dec_src2  = imm_sext;
        dec_dest  = f_rt;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_legal = 1'b1;
        dec_aluop = (f_op == OP_ANDI) ? ALU_AND :
                    (f_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec_src1  = in_rs_value;
        dec_src2  = imm_zext;
        dec_dest  = f_rt;
      end
      OP_LUI: begin
        // ALU performs the shift-by-16; only the raw immediate is passed
        dec_legal = 1'b1;
        dec_aluop = ALU_LUI;
        dec_src1  = '0;
        dec_src2  = imm_zext;
        dec_dest  = f_rt;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // $0 is hard-wired, so writes to it are suppressed
  assign dec_we = dec_legal && (dec_dest != '0);

  // Single-entry slot: accept when empty or being drained this cycle
  logic load;
  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // ID/EX slot register; reset dominates flush, flush dominates load
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_aluop   <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_dest    <= '0;
      out_we      <= 1'b0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_aluop   <= dec_aluop;
      out_src1    <= dec_src1;
      out_src2    <= dec_src2;
      out_dest    <= dec_dest;
      out_we      <= dec_we;
      out_pc      <= in_pc;
      out_illegal <= ~dec_legal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: table-driven decode checks plus directed handshake
// sequences (backpressure, flush, reset interactions) for alu_op_issue.
module tb_alu_op_issue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs_value;
  logic [31:0] in_rt_value;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_aluop;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [4:0]  out_dest;
  logic        out_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  alu_op_issue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs_value (in_rs_value),
    .in_rt_value (in_rt_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluop   (out_aluop),
    .out_src1    (out_src1),
    .out_src2    (out_src2),
    .out_dest    (out_dest),
    .out_we      (out_we),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare the whole held slot against a vector
  task automatic chk_slot(input string tag, input vec_t v);
    chk({tag, " valid"},   32'(out_valid),   32'd1);
    chk({tag, " aluop"},   32'(out_aluop),   32'(v.aluop));
    chk({tag, " src1"},    out_src1,         v.src1);
    chk({tag, " src2"},    out_src2,         v.src2);
    chk({tag, " dest"},    32'(out_dest),    32'(v.dest));
    chk({tag, " we"},      32'(out_we),      32'(v.we));
    chk({tag, " illegal"}, 32'(out_illegal), 32'(v.ill));
    chk({tag, " pc"},      out_pc,           v.pc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"},   32'(out_valid),   32'd0);
    chk({tag, " aluop"},   32'(out_aluop),   32'd0);
    chk({tag, " src1"},    out_src1,         32'd0);
    chk({tag, " src2"},    out_src2,         32'd0);
    chk({tag, " dest"},    32'(out_dest),    32'd0);
    chk({tag, " we"},      32'(out_we),      32'd0);
    chk({tag, " illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, " pc"},      out_pc,           32'd0);
  endtask

  task automatic drive(input vec_t v);
    in_valid    = 1'b1;
    in_inst     = v.inst;
    in_pc       = v.pc;
    in_rs_value = v.rs;
    in_rt_value = v.rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            inst          pc            rs            rt            op     src1          src2          dest we ill
    vecs[0]  = '{32'h2509FFFF, 32'h00001000, 32'h00000005, 32'h11111111, 5'd0,  32'h00000005, 32'hFFFFFFFF, 5'd9,  1'b1, 1'b0}; // ADDIU
    vecs[1]  = '{32'h00095100, 32'h00001004, 32'h00000077, 32'h00000003, 5'd8,  32'h00000004, 32'h00000003, 5'd10, 1'b1, 1'b0}; // SLL
    vecs[2]  = '{32'h01095004, 32'h00001008, 32'h0000001F, 32'hDEADBEEF, 5'd8,  32'h0000001F, 32'hDEADBEEF, 5'd10, 1'b1, 1'b0}; // SLLV
    vecs[3]  = '{32'h3C0B1234, 32'h0000100C, 32'h0000AAAA, 32'h55555555, 5'd11, 32'h00000000, 32'h00001234, 5'd11, 1'b1, 1'b0}; // LUI
    vecs[4]  = '{32'h3109FFFF, 32'h00001010, 32'h12345678, 32'h0BADF00D, 5'd4,  32'h12345678, 32'h0000FFFF, 5'd9,  1'b1, 1'b0}; // ANDI
    vecs[5]  = '{32'hFC000000, 32'h00001014, 32'hCAFEBABE, 32'h87654321, 5'd0,  32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1}; // illegal op
    vecs[6]  = '{32'h01090021, 32'h00001018, 32'h00000010, 32'h00000020, 5'd0,  32'h00000010, 32'h00000020, 5'd0,  1'b0, 1'b0}; // ADDU $0
    vecs[7]  = '{32'h00221823, 32'h0000101C, 32'h00000100, 32'h00000001, 5'd1,  32'h00000100, 32'h00000001, 5'd3,  1'b1, 1'b0}; // SUBU
    vecs[8]  = '{32'h000227C3, 32'h00001020, 32'h0000FFFF, 32'h80000000, 5'd10, 32'h0000001F, 32'h80000000, 5'd4,  1'b1, 1'b0}; // SRA sa=31
    vecs[9]  = '{32'h28258000, 32'h00001024, 32'h00000002, 32'h00000003, 5'd2,  32'h00000002, 32'hFFFF8000, 5'd5,  1'b1, 1'b0}; // SLTI
    vecs[10] = '{32'h34068001, 32'h00001028, 32'hA5A5A5A5, 32'h00000000, 5'd6,  32'hA5A5A5A5, 32'h00008001, 5'd6,  1'b1, 1'b0}; // ORI
    vecs[11] = '{32'h00221801, 32'h0000102C, 32'h00000007, 32'h00000008, 5'd0,  32'h00000000, 32'h00000000, 5'd0,  1'b0, 1'b1}; // illegal fn
    vecs[12] = '{32'h00221827, 32'h00001030, 32'h0F0F0F0F, 32'h00FF00FF, 5'd5,  32'h0F0F0F0F, 32'h00FF00FF, 5'd3,  1'b1, 1'b0}; // NOR
    vecs[13] = '{32'h00221806, 32'h00001034, 32'h00000004, 32'hF0000000, 5'd9,  32'h00000004, 32'hF0000000, 5'd3,  1'b1, 1'b0}; // SRLV
    vecs[14] = '{32'h3807F0F0, 32'h00001038, 32'h0000FFFF, 32'h00000000, 5'd7,  32'h0000FFFF, 32'h0000F0F0, 5'd7,  1'b1, 1'b0}; // XORI
    vecs[15] = '{32'h2C08FFFE, 32'h0000103C, 32'h00000009, 32'h00000000, 5'd3,  32'h00000009, 32'hFFFFFFFE, 5'd8,  1'b1, 1'b0}; // SLTIU

    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_inst     = '0;
    in_pc       = '0;
    in_rs_value = '0;
    in_rt_value = '0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Back-to-back table vectors, sink always ready
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      chk_slot($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: slot holds vecs[15]; new instruction offered for 3 cycles
    out_ready = 1'b0;
    drive(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      step();
      chk_slot($sformatf("bp%0d hold", c), vecs[15]);
    end
    // Release: in_ready rises in the same cycle; next slot loads with no bubble
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    chk_slot("bp load", vecs[0]);

    // Idle drain: nothing offered, consumer ready -> slot empties
    in_valid = 1'b0;
    step();
    chk("drain valid", 32'(out_valid), 32'd0);

    // Flush with slot full and a new instruction offered
    drive(vecs[3]);
    step();
    chk_slot("pre-flush", vecs[3]);
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(vecs[4]);
    step();
    chk("flush valid", 32'(out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-flush valid", 32'(out_valid), 32'd0);
    chk("post-flush pc", out_pc, vecs[3].pc);

    // Flush on an empty slot still drops the incoming instruction
    out_ready = 1'b1;
    flush     = 1'b1;
    drive(vecs[7]);
    step();
    chk("flush empty valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;

    // Flush and reset together clear everything
    drive(vecs[9]);
    step();
    chk_slot("pre-rstflush", vecs[9]);
    reset = 1'b1;
    flush = 1'b1;
    drive(vecs[10]);
    step();
    chk_all_zero("rst+flush");
    reset = 1'b0;
    flush = 1'b0;

    // Reset mid-transfer: the handshake in that cycle is lost
    drive(vecs[12]);
    reset = 1'b1;
    step();
    chk_all_zero("rst handshake");
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-rst valid", 32'(out_valid), 32'd0);

    // Operands are captured: changing inputs while held has no effect
    drive(vecs[1]);
    step();
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    in_rt_value = 32'hFFFFFFFF;
    in_inst     = 32'h3C0B1234;
    step();
    chk_slot("capture", vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
